// File: rtl/kstep_spi_controller.sv
// SPI mode-0 master, MSB first, 8-bit words. Multi-byte transactions keep spi_cs
// low between bytes until a byte tagged last has been shifted out.
module kstep_spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CNT = (MAX_AB > CS_HOLD) ? MAX_AB : CS_HOLD;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic             high_r, high_s;
    // bit 7 of the byte goes straight to spi_mosi on load, so only 7 bits are kept
    logic [6:0]       tx_sh_r, tx_sh_s;
    logic             last_r, last_s;
    logic [6:0]       rx_sh_r, rx_sh_s;
    logic [7:0]       rx_data_r, rx_data_s;
    logic             rx_valid_r, rx_valid_s;
    logic             ready_r, ready_s;
    logic             busy_r, busy_s;
    logic             cs_r, cs_s;
    logic             sclk_r, sclk_s;
    logic             mosi_r, mosi_s;

    assign tx_ready = ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign busy     = busy_r;
    assign spi_cs   = cs_r;
    assign spi_sclk = sclk_r;
    assign spi_mosi = mosi_r;

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_s      = bit_r;
        high_s     = high_r;
        tx_sh_s    = tx_sh_r;
        last_s     = last_r;
        rx_sh_s    = rx_sh_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        sclk_s     = sclk_r;
        mosi_s     = mosi_r;

        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_s = ST_SETUP;
                    cnt_s   = CNT_ZERO;
                    tx_sh_s = tx_data[6:0];
                    last_s  = tx_last;
                    mosi_s  = tx_data[7];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = ST_XFER;
                    cnt_s   = CNT_ZERO;
                    high_s  = 1'b0;
                    bit_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_XFER: begin
                if (cnt_r != DIV_LAST) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else if (!high_r) begin
                    cnt_s  = CNT_ZERO;
                    high_s = 1'b1;
                    sclk_s = 1'b1;
                end else begin
                    // last cycle of the high phase: MISO is taken as late as possible
                    cnt_s   = CNT_ZERO;
                    high_s  = 1'b0;
                    sclk_s  = 1'b0;
                    rx_sh_s = {rx_sh_r[5:0], spi_miso};
                    if (bit_r == 3'd7) begin
                        rx_valid_s = 1'b1;
                        rx_data_s  = {rx_sh_r, spi_miso};
                        if (last_r) begin
                            state_s = ST_HOLD;
                        end else begin
                            state_s = ST_NEXT;
                        end
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        mosi_s  = tx_sh_r[6];
                        tx_sh_s = {tx_sh_r[5:0], 1'b0};
                    end
                end
            end
            ST_NEXT: begin
                if (tx_valid) begin
                    state_s = ST_XFER;
                    cnt_s   = CNT_ZERO;
                    high_s  = 1'b0;
                    bit_s   = 3'd0;
                    tx_sh_s = tx_data[6:0];
                    last_s  = tx_last;
                    mosi_s  = tx_data[7];
                end else begin
                    state_s = ST_NEXT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                sclk_s  = 1'b0;
            end
        endcase

        cs_s    = (state_s == ST_IDLE);
        ready_s = (state_s == ST_IDLE) || (state_s == ST_NEXT);
        busy_s  = (state_s != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_r      <= 3'd0;
            high_r     <= 1'b0;
            tx_sh_r    <= 7'd0;
            last_r     <= 1'b0;
            rx_sh_r    <= 7'd0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            cs_r       <= 1'b1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_r      <= bit_s;
            high_r     <= high_s;
            tx_sh_r    <= tx_sh_s;
            last_r     <= last_s;
            rx_sh_r    <= rx_sh_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            cs_r       <= cs_s;
            sclk_r     <= sclk_s;
            mosi_r     <= mosi_s;
        end
    end

endmodule

// File: tb/tb_kstep_spi_controller.sv
// Bench for kstep_spi_controller: a table of bytes (directed + random) runs against
// a mode-0 slave model; data and cycle timing are predicted from the transfer rules.
module tb_kstep_spi_controller;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int NV       = 20;

    typedef struct {
        logic [7:0] tx;
        logic       last;
        logic [7:0] miso;
        int         gap;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, rx_data;
    logic       tx_last, tx_valid, tx_ready, rx_valid, busy;
    logic       spi_cs, spi_sclk, spi_mosi, spi_miso;

    logic [7:0] tx_data1, rx_data1;
    logic       tx_last1, tx_valid1, tx_ready1, rx_valid1, busy1;
    logic       spi_cs1, spi_sclk1, spi_mosi1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kstep_spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // second instance at the fastest divider, MISO looped back to MOSI
    kstep_spi_controller #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_last(tx_last1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .spi_cs(spi_cs1), .spi_sclk(spi_sclk1), .spi_mosi(spi_mosi1), .spi_miso(spi_mosi1)
    );

    // Mode-0 slave: presents bit 7 when selected, advances one bit per SCLK falling edge.
    logic [7:0] slave_mem [0:15];
    logic [7:0] fall_n = 8'd0;
    logic [7:0] cur_slave;
    assign cur_slave = slave_mem[fall_n[6:3]];
    assign spi_miso  = cur_slave[~fall_n[2:0]];

    logic [7:0] rx_q [$];
    int         rxc_q [$];
    logic       mosi_q [$];
    int         n_cs_fall = 0, n_cs_rise = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            rxc_q.push_back(cyc);
        end
        if (prev_sclk === 1'b0 && spi_sclk === 1'b1) mosi_q.push_back(spi_mosi);
        if (prev_cs === 1'b1 && spi_cs === 1'b0) begin n_cs_fall++; cs_fall_cyc = cyc; end
        if (prev_cs === 1'b0 && spi_cs === 1'b1) begin n_cs_rise++; cs_rise_cyc = cyc; end
        if (spi_cs !== 1'b0) fall_n = 8'd0;
        else if (prev_sclk === 1'b1 && spi_sclk === 1'b0) fall_n = fall_n + 8'd1;
        prev_cs   = spi_cs;
        prev_sclk = spi_sclk;
    end

    vec_t tbl [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int h);
        bit got;
        got = 1'b0;
        h   = -1;
        @(posedge clk); #1;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk); #1;
            if (tx_ready === 1'b1) begin got = 1'b1; h = cyc; end
        end
        check("handshake_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
    endtask

    task automatic run_txn(input int first, input int cnt);
        int         h [8];
        int         rb, mb, fb, rsb, r_exp;
        bit         ok;
        logic [7:0] mbyte;
        for (int k = 0; k < 16; k++) slave_mem[k] = (k < cnt) ? tbl[first + k].miso : 8'h00;
        rb  = rx_q.size();
        mb  = mosi_q.size();
        fb  = n_cs_fall;
        rsb = n_cs_rise;
        for (int k = 0; k < cnt; k++) begin
            if (k > 0 && tbl[first + k].gap > 0) begin
                for (int i = 0; i < 400 && rx_q.size() < rb + k; i++) begin @(negedge clk); #1; end
                ok = 1'b1;
                for (int i = 0; i < tbl[first + k].gap; i++) begin
                    @(negedge clk); #1;
                    if (spi_cs !== 1'b0 || spi_sclk !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) ok = 1'b0;
                end
                check("next_wait_steady", {31'd0, ok}, 32'd1);
            end
            send_byte(tbl[first + k].tx, tbl[first + k].last, h[k]);
        end
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (spi_cs === 1'b1) ok = 1'b1;
        end
        check("cs_released", {31'd0, ok}, 32'd1);
        check("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("rx_count", rx_q.size() - rb, cnt);
        for (int k = 0; k < cnt; k++) begin
            if (rb + k < rx_q.size()) begin
                r_exp = h[k] + 1 + 16 * CLK_DIV + ((k == 0) ? CS_SETUP : 0);
                check("rx_data", {24'd0, rx_q[rb + k]}, {24'd0, tbl[first + k].exp_rx});
                check("rx_valid_cycle", rxc_q[rb + k], r_exp);
            end
        end
        check("sclk_rises", mosi_q.size() - mb, 8 * cnt);
        for (int k = 0; k < cnt; k++) begin
            mbyte = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (mb + 8 * k + b < mosi_q.size()) mbyte = {mbyte[6:0], mosi_q[mb + 8 * k + b]};
            end
            check("mosi_byte", {24'd0, mbyte}, {24'd0, tbl[first + k].exp_mosi});
        end
        check("cs_fall_once", n_cs_fall - fb, 1);
        check("cs_rise_once", n_cs_rise - rsb, 1);
        check("cs_fall_cycle", cs_fall_cyc, h[0] + 1);
        if (rx_q.size() > rb) check("cs_rise_cycle", cs_rise_cyc, rxc_q[rx_q.size() - 1] + CS_HOLD);
    endtask

    initial begin
        int   i, j, hv, target, rb0, h1, r1;
        int   glen;
        bit   got;
        logic [7:0] d1;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        tx_valid1 = 1'b0; tx_data1 = 8'h00; tx_last1 = 1'b0;
        for (int k = 0; k < 16; k++) slave_mem[k] = 8'h00;

        tbl[0] = '{8'hA5, 1'b1, 8'h3C, 0,  8'h3C, 8'hA5};
        tbl[1] = '{8'h01, 1'b0, 8'h5A, 0,  8'h5A, 8'h01};
        tbl[2] = '{8'h80, 1'b1, 8'hC3, 0,  8'hC3, 8'h80};
        tbl[3] = '{8'h12, 1'b0, 8'h34, 0,  8'h34, 8'h12};
        tbl[4] = '{8'hFF, 1'b1, 8'h81, 20, 8'h81, 8'hFF};
        tbl[5] = '{8'h0F, 1'b1, 8'h96, 0,  8'h96, 8'h0F};
        glen = 0;
        for (int k = 6; k < NV; k++) begin
            glen++;
            tbl[k].tx       = 8'($urandom);
            tbl[k].miso     = 8'($urandom);
            tbl[k].last     = (k == NV - 1) || (glen == 3) || ($urandom_range(0, 1) == 1);
            tbl[k].gap      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            tbl[k].exp_rx   = tbl[k].miso;
            tbl[k].exp_mosi = tbl[k].tx;
            if (tbl[k].last) glen = 0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cs", {31'd0, spi_cs}, 32'd1);
        check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_cs_div1", {31'd0, spi_cs1}, 32'd1);
        rst = 1'b0;

        i = 0;
        while (i < NV) begin
            if (i == 5) begin
                rb0 = rx_q.size();
                send_byte(8'h55, 1'b1, hv);
                target = hv + 1 + CS_SETUP + CLK_DIV + 2 * CLK_DIV * 3;
                for (int k = 0; k < 200 && cyc < target; k++) begin @(negedge clk); #1; end
                check("midbyte_sclk_high", {31'd0, spi_sclk}, 32'd1);
                check("midbyte_cs_low", {31'd0, spi_cs}, 32'd0);
                rst = 1'b1;
                @(negedge clk); #1;
                check("abort_cs", {31'd0, spi_cs}, 32'd1);
                check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
                check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
                check("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
                check("abort_busy", {31'd0, busy}, 32'd0);
                rst = 1'b0;
                repeat (80) begin @(negedge clk); #1; end
                check("abort_no_rx_valid", rx_q.size(), rb0);
            end
            j = i;
            while (j < NV - 1 && !tbl[j].last) j++;
            run_txn(i, j - i + 1);
            i = j + 1;
        end

        // divider of one: each byte spans 16 cycles and loops back unchanged
        @(posedge clk); #1;
        tx_data1 = 8'hC3; tx_last1 = 1'b1; tx_valid1 = 1'b1;
        got = 1'b0; h1 = -1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); #1;
            if (tx_ready1 === 1'b1) begin got = 1'b1; h1 = cyc; end
        end
        @(posedge clk); #1;
        tx_valid1 = 1'b0; tx_data1 = 8'h00;
        got = 1'b0; r1 = -1; d1 = 8'h00;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk); #1;
            if (rx_valid1 === 1'b1) begin got = 1'b1; r1 = cyc; d1 = rx_data1; end
        end
        check("div1_rx_seen", {31'd0, got}, 32'd1);
        check("div1_rx_data", {24'd0, d1}, 32'h000000C3);
        check("div1_rx_cycle", r1, h1 + 1 + CS_SETUP + 16);
        repeat (CS_HOLD) begin @(negedge clk); #1; end
        check("div1_cs_released", {31'd0, spi_cs1}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
